// File: rtl/tx_frame_arbiter_if.sv
// Request/acknowledge handshakes plus the UART TX byte port of the frame arbiter.
// The arbiter takes the slave side; requesters and the TX model take the master side.
interface tx_frame_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    req0_vld;
    logic [DATA_WIDTH-1:0]   req0_data;
    logic                    req0_ack;
    logic                    req1_vld;
    logic [2*DATA_WIDTH-1:0] req1_data;
    logic                    req1_ack;
    logic                    tx_busy;
    logic [DATA_WIDTH-1:0]   tx_p_data;
    logic                    tx_d_vld;
    logic                    arb_busy;
    logic                    err;

    modport master (
        output req0_vld, req0_data, req1_vld, req1_data, tx_busy,
        input  req0_ack, req1_ack, tx_p_data, tx_d_vld, arb_busy, err
    );

    modport slave (
        input  req0_vld, req0_data, req1_vld, req1_data, tx_busy,
        output req0_ack, req1_ack, tx_p_data, tx_d_vld, arb_busy, err
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that serialises 1-byte (REQ0) and 2-byte (REQ1) frames onto a UART TX,
// pacing each byte on the TX busy handshake with a sticky timeout error.
module tx_frame_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    tx_frame_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [1:0]              bytes_q, bytes_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
    logic                    tx_d_vld_q, tx_d_vld_d;
    logic                    req0_ack_q, req0_ack_d;
    logic                    req1_ack_q, req1_ack_d;
    logic                    arb_busy_q, arb_busy_d;
    logic                    err_q, err_d;
    logic                    grant0;
    logic                    grant1;

    // last_q=1 means REQ1 was served last, so REQ0 wins a tie.
    always_comb begin
        grant0 = bus.req0_vld & (~bus.req1_vld | last_q);
        grant1 = bus.req1_vld & ~grant0;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        bytes_d     = bytes_q;
        hold_d      = hold_q;
        tx_p_data_d = tx_p_data_q;
        tx_d_vld_d  = 1'b0;
        req0_ack_d  = 1'b0;
        req1_ack_d  = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && (grant0 || grant1)) begin
                    state_d    = SEND;
                    tx_d_vld_d = 1'b1;
                    last_d     = grant1;
                    if (grant0) begin
                        hold_d      = {{DATA_WIDTH{1'b0}}, bus.req0_data};
                        bytes_d     = 2'd1;
                        req0_ack_d  = 1'b1;
                        tx_p_data_d = bus.req0_data;
                    end else begin
                        hold_d      = bus.req1_data;
                        bytes_d     = 2'd2;
                        req1_ack_d  = 1'b1;
                        tx_p_data_d = bus.req1_data[DATA_WIDTH-1:0];
                    end
                end
            end

            // The byte on the wire is consumed here, so the holding register
            // always presents the next byte in its low lane.
            SEND: begin
                state_d = WAIT_HI;
                cnt_d   = 8'd0;
                bytes_d = bytes_q - 2'd1;
                hold_d  = {{DATA_WIDTH{1'b0}}, hold_q[2*DATA_WIDTH-1:DATA_WIDTH]};
            end

            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    bytes_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (bytes_q != 2'd0) begin
                        state_d     = SEND;
                        tx_d_vld_d  = 1'b1;
                        tx_p_data_d = hold_q[DATA_WIDTH-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= 8'd0;
            bytes_q     <= 2'd0;
            hold_q      <= '0;
            tx_p_data_q <= '0;
            tx_d_vld_q  <= 1'b0;
            req0_ack_q  <= 1'b0;
            req1_ack_q  <= 1'b0;
            arb_busy_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bytes_q     <= bytes_d;
            hold_q      <= hold_d;
            tx_p_data_q <= tx_p_data_d;
            tx_d_vld_q  <= tx_d_vld_d;
            req0_ack_q  <= req0_ack_d;
            req1_ack_q  <= req1_ack_d;
            arb_busy_q  <= arb_busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_p_data = tx_p_data_q;
    assign bus.tx_d_vld  = tx_d_vld_q;
    assign bus.req0_ack  = req0_ack_q;
    assign bus.req1_ack  = req1_ack_q;
    assign bus.arb_busy  = arb_busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: tests queue the bytes they expect on the TX port and a
// negedge monitor pops and compares every TX_D_VLD pulse; a small model emulates UART busy.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;
    localparam int DATA_WIDTH = 8;
    localparam int TIMEOUT    = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] mon_exp;
    int pulse_cnt = 0;
    int ack0_cnt  = 0;
    int ack1_cnt  = 0;

    logic model_en    = 1'b1;
    logic model_raise = 1'b1;
    logic model_busy  = 1'b0;
    logic manual_busy = 1'b0;
    int   dly_cnt     = 0;
    int   hi_cnt      = 0;

    tx_frame_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    tx_frame_arbiter #(
        .DATA_WIDTH(DATA_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.tx_busy = model_en ? model_busy : manual_busy;

    always #5 clk = ~clk;

    // UART emulation: busy rises 2 cycles after a byte pulse and stays high for 10 cycles.
    always @(negedge clk) begin
        if (rst) begin
            model_busy = 1'b0;
            dly_cnt    = 0;
            hi_cnt     = 0;
        end else if (bus.tx_d_vld === 1'b1) begin
            if (model_raise) dly_cnt = 2;
        end else if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) begin
                model_busy = 1'b1;
                hi_cnt     = 10;
            end
        end else if (hi_cnt > 0) begin
            hi_cnt--;
            if (hi_cnt == 0) model_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_ack === 1'b1) ack0_cnt++;
            if (bus.req1_ack === 1'b1) ack1_cnt++;
            if (bus.tx_d_vld === 1'b1) begin
                pulse_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL tx_byte_unexpected: got %h, expected no pulse", bus.tx_p_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.tx_p_data !== mon_exp) begin
                        tests_failed++;
                        $display("[TB] FAIL tx_byte: got %h, expected %h", bus.tx_p_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input int limit, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.arb_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int limit, output bit got0, output bit got1, output bit ok);
        ok   = 1'b0;
        got0 = 1'b0;
        got1 = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.req0_ack === 1'b1 || bus.req1_ack === 1'b1) begin
                got0 = bus.req0_ack;
                got1 = bus.req1_ack;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [DATA_WIDTH+4:0] outs;
        rst            = 1'b1;
        bus.req0_vld   = 1'b0;
        bus.req0_data  = '0;
        bus.req1_vld   = 1'b0;
        bus.req1_data  = '0;
        tick(3);
        outs = {bus.tx_p_data, bus.tx_d_vld, bus.req0_ack, bus.req1_ack, bus.arb_busy, bus.err};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
        tick(2);
        tests_run++;
        if (bus.arb_busy !== 1'b0 || bus.tx_d_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got arb_busy=%b tx_d_vld=%b, expected 0 0", bus.arb_busy, bus.tx_d_vld);
        end
    endtask

    task automatic test_single_req0();
        int p0, a0, a1, cyc;
        bit ok;
        p0 = pulse_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
        bus.req0_data = 8'hA5;
        exp_q.push_back(8'hA5);
        bus.req0_vld = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.req0_ack, bus.req1_ack, bus.tx_d_vld, bus.arb_busy} !== 4'b1011) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: got ack0/ack1/vld/busy=%b, expected 1011",
                     {bus.req0_ack, bus.req1_ack, bus.tx_d_vld, bus.arb_busy});
        end
        bus.req0_vld = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.req0_ack !== 1'b0 || bus.tx_d_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_pulse_width: got ack0=%b vld=%b, expected 0 0", bus.req0_ack, bus.tx_d_vld);
        end
        wait_idle(100, cyc, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL single_idle: got still busy after %0d cycles, expected idle", cyc);
        end
        tick(2);
        tests_run++;
        if (pulse_cnt - p0 !== 1 || ack0_cnt - a0 !== 1 || ack1_cnt - a1 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL single_counts: got pulses=%0d ack0=%0d ack1=%0d, expected 1 1 0",
                     pulse_cnt - p0, ack0_cnt - a0, ack1_cnt - a1);
        end
        tests_run++;
        if (bus.err !== 1'b0 || bus.tx_p_data !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL single_err_hold: got err=%b data=%h, expected 0 a5", bus.err, bus.tx_p_data);
        end
    endtask

    task automatic test_req1_two_bytes();
        int p0, a0, a1, cyc;
        bit ok;
        p0 = pulse_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
        bus.req1_data = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        bus.req1_vld = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.req0_ack, bus.req1_ack, bus.tx_d_vld, bus.tx_p_data} !== {3'b011, 8'h34}) begin
            tests_failed++;
            $display("[TB] FAIL req1_grant: got ack0/ack1/vld=%b data=%h, expected 011 34",
                     {bus.req0_ack, bus.req1_ack, bus.tx_d_vld}, bus.tx_p_data);
        end
        bus.req1_vld = 1'b0;
        wait_idle(200, cyc, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL req1_idle: got still busy after %0d cycles, expected idle", cyc);
        end
        tick(2);
        tests_run++;
        if (pulse_cnt - p0 !== 2 || ack1_cnt - a1 !== 1 || ack0_cnt - a0 !== 0) begin
            tests_failed++;
            $display("[TB] FAIL req1_counts: got pulses=%0d ack1=%0d ack0=%0d, expected 2 1 0",
                     pulse_cnt - p0, ack1_cnt - a1, ack0_cnt - a0);
        end
        tests_run++;
        if (bus.tx_p_data !== 8'h12) begin
            tests_failed++;
            $display("[TB] FAIL req1_hold: got %h, expected 12", bus.tx_p_data);
        end
    endtask

    task automatic test_round_robin();
        bit exp_last, exp_win, got0, got1, ok;
        int cyc;
        logic [15:0] r1;
        do_reset();
        exp_last      = 1'b1;
        bus.req0_data = 8'h41;
        bus.req1_data = 16'hC1B1;
        for (int g = 0; g < 4; g++) begin
            exp_win = (exp_last == 1'b1) ? 1'b0 : 1'b1;
            if (!exp_win) begin
                exp_q.push_back(bus.req0_data);
            end else begin
                r1 = bus.req1_data;
                exp_q.push_back(r1[7:0]);
                exp_q.push_back(r1[15:8]);
            end
            if (g == 0) begin
                bus.req0_vld = 1'b1;
                bus.req1_vld = 1'b1;
            end
            wait_ack(300, got0, got1, ok);
            tests_run++;
            if (!ok || {got0, got1} !== (exp_win ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("[TB] FAIL rr_grant_%0d: got ack0/ack1=%b%b ok=%b, expected %b",
                         g, got0, got1, ok, (exp_win ? 2'b01 : 2'b10));
            end
            exp_last = exp_win;
            if (g == 3) begin
                bus.req0_vld = 1'b0;
                bus.req1_vld = 1'b0;
            end else if (!exp_win) begin
                bus.req0_vld = 1'b0;
                @(negedge clk);
                bus.req0_data = bus.req0_data + 8'h01;
                bus.req0_vld  = 1'b1;
            end else begin
                bus.req1_vld = 1'b0;
                @(negedge clk);
                bus.req1_data = bus.req1_data + 16'h0101;
                bus.req1_vld  = 1'b1;
            end
        end
        wait_idle(300, cyc, ok);
        tick(2);
        tests_run++;
        if (!ok || exp_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL rr_drain: got idle=%b pending=%0d, expected 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int p0, cyc;
        bit got0, got1, ok;
        p0 = pulse_cnt;
        model_raise   = 1'b0;
        bus.req1_data = 16'hBEEF;
        exp_q.push_back(8'hEF);
        bus.req1_vld = 1'b1;
        wait_ack(20, got0, got1, ok);
        bus.req1_vld = 1'b0;
        tests_run++;
        if (!ok || got1 !== 1'b1 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_grant: got ok=%b ack1=%b err=%b, expected 1 1 0", ok, got1, bus.err);
        end
        wait_idle(400, cyc, ok);
        tests_run++;
        if (!ok || cyc !== TIMEOUT + 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycles: got %0d (ok=%b), expected %0d", cyc, ok, TIMEOUT + 1);
        end
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_err: got %b, expected 1", bus.err);
        end
        tick(5);
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_no_second_byte: got %0d pulses, expected 1", pulse_cnt - p0);
        end
        model_raise   = 1'b1;
        bus.req0_data = 8'h5A;
        exp_q.push_back(8'h5A);
        bus.req0_vld = 1'b1;
        wait_ack(20, got0, got1, ok);
        bus.req0_vld = 1'b0;
        wait_idle(100, cyc, ok);
        tick(2);
        tests_run++;
        if (!ok || got0 !== 1'b1 || bus.err !== 1'b1 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_recover: got idle=%b ack0=%b err=%b pending=%0d, expected 1 1 1 0",
                     ok, got0, bus.err, exp_q.size());
        end
    endtask

    task automatic test_busy_block();
        int cyc;
        bit ok;
        model_en      = 1'b0;
        manual_busy   = 1'b1;
        bus.req0_data = 8'h3C;
        exp_q.push_back(8'h3C);
        bus.req0_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.req0_ack !== 1'b0 || bus.arb_busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL busy_block_%0d: got ack0=%b arb_busy=%b, expected 0 0",
                         i, bus.req0_ack, bus.arb_busy);
            end
        end
        manual_busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.req0_ack !== 1'b1 || bus.tx_p_data !== 8'h3C) begin
            tests_failed++;
            $display("[TB] FAIL busy_release_grant: got ack0=%b data=%h, expected 1 3c", bus.req0_ack, bus.tx_p_data);
        end
        bus.req0_vld = 1'b0;
        model_en     = 1'b1;
        wait_idle(100, cyc, ok);
        tests_run++;
        if (!ok || bus.err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_release_idle: got idle=%b err=%b, expected 1 1", ok, bus.err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0, a0, a1;
        bit got0, got1, ok, seen;
        logic [DATA_WIDTH+4:0] outs;
        bus.req1_data = 16'h5678;
        exp_q.push_back(8'h78);
        bus.req1_vld = 1'b1;
        wait_ack(20, got0, got1, ok);
        bus.req1_vld = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tick(2);
        tests_run++;
        if (!ok || !seen || bus.arb_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_setup: got ack=%b busy_seen=%b arb_busy=%b, expected 1 1 1",
                     ok, seen, bus.arb_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        outs = {bus.tx_p_data, bus.tx_d_vld, bus.req0_ack, bus.req1_ack, bus.arb_busy, bus.err};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
        p0 = pulse_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
        tick(30);
        tests_run++;
        if (pulse_cnt !== p0 || ack0_cnt !== a0 || ack1_cnt !== a1 || exp_q.size() !== 0 || bus.arb_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_aborted: got pulses=%0d acks=%0d pending=%0d arb_busy=%b, expected 0 0 0 0",
                     pulse_cnt - p0, (ack0_cnt - a0) + (ack1_cnt - a1), exp_q.size(), bus.arb_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_req1_two_bytes();
        test_round_robin();
        test_timeout();
        test_busy_block();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of one UART TX byte.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles spent waiting for busy to rise after a byte is issued (8-bit counter).
REQ-003 CLK  input  1  REF_CLK-domain clock; single clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 REQ0_VLD  input  1  RF read-response request; held high until REQ0_ACK.
REQ-006 REQ0_DATA  input  DATA_WIDTH  RF read byte; 1-byte frame.
REQ-007 REQ0_ACK  output  1  one-cycle pulse; REQ0 frame accepted.
REQ-008 REQ1_VLD  input  1  ALU-result request; held high until REQ1_ACK.
REQ-009 REQ1_DATA  input  2*DATA_WIDTH  ALU result; 2-byte frame, low byte first.
REQ-010 REQ1_ACK  output  1  one-cycle pulse; REQ1 frame accepted.
REQ-011 TX_BUSY  input  1  UART TX busy, already synchronized to CLK.
REQ-012 TX_P_DATA  output  DATA_WIDTH  byte to UART TX data synchronizer.
REQ-013 TX_D_VLD  output  1  one-cycle byte-valid pulse.
REQ-014 ARB_BUSY  output  1  high whenever state is not IDLE.
REQ-015 ERR  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, SEND, WAIT_HI and WAIT_LO; all outputs SHALL be registered.
REQ-017 IDLE: grant only when TX_BUSY=0 and at least one VLD is high; a request is never granted while TX_BUSY=1.
REQ-018 Arbitration: round-robin with a LAST register; when both VLD are high, the requester not equal to LAST wins; a lone requester always wins.
REQ-019 On grant at edge N: frame data captured into a holding register; byte count set (REQ0=1, REQ1=2); LAST updated; state goes to SEND; the granted REQn_ACK is high for exactly cycle N+1.
REQ-020 SEND (one cycle): TX_D_VLD=1 and TX_P_DATA=current byte; then goes to WAIT_HI with timeout counter cleared.
REQ-021 TX_P_DATA SHALL hold its value until the next SEND.
REQ-022 WAIT_HI: if TX_BUSY=1, go to WAIT_LO; else increment counter; at counter==TIMEOUT-1 set ERR=1, discard remaining bytes and go to IDLE.
REQ-023 WAIT_LO: on TX_BUSY=0, go to SEND with the next byte (REQ1 high byte) if bytes remain, else go to IDLE.
REQ-024 REQ1 frame byte order: REQ1_DATA[7:0] first, then REQ1_DATA[15:8]; the two bytes are never interleaved with a REQ0 byte.
REQ-025 VLD still high in the IDLE cycle after ACK SHALL be treated as a new request; requesters drop VLD on ACK.
REQ-026 VLD changes outside IDLE SHALL be ignored; the captured data is unaffected.
REQ-027 ERR SHALL remain 1 until reset; the arbiter continues to operate normally after a timeout.

Reset
REQ-028 While RST=1 at a clock edge: state=IDLE, LAST=REQ1 (so REQ0 wins the first tie), counter=0, byte count=0, holding register=0, TX_P_DATA=0, TX_D_VLD=0, REQn_ACK=0, ARB_BUSY=0, ERR=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further TX_D_VLD and no ACK pulses.

Verification
REQ-030 REQ0_VLD=1, REQ0_DATA=0xA5, TX_BUSY low, busy raised 2 cycles after the pulse and lowered 10 cycles later -> REQ0_ACK at N+1, one TX_D_VLD with 0xA5, IDLE after busy falls, ERR=0.
REQ-031 REQ1_DATA=0x1234 -> TX_D_VLD carrying 0x34, busy cycle, then TX_D_VLD carrying 0x12; exactly two pulses; one REQ1_ACK.
REQ-032 Both VLD high from reset, each re-requesting after ACK -> grant order REQ0, REQ1, REQ0, REQ1; no starvation.
REQ-033 TX_BUSY held 0 after SEND, TIMEOUT=255 -> return to IDLE 255 cycles after WAIT_HI entry; ERR=1; REQ1 second byte never sent; next request serviced normally.
REQ-034 TX_BUSY=1 while REQ0_VLD rises -> no grant until TX_BUSY=0, then grant on the next edge.
REQ-035 RST pulsed in WAIT_LO of a REQ1 frame -> all outputs return to reset values; no second byte is sent.
